// File: rtl/mem_if_defs.sv
// Shared load/store interface definitions: size codes, responder FSM states and
// the request payload reused by the core's load/store unit.
package mem_if_defs;

    localparam int unsigned REQ_ADDR_W = 32;
    localparam int unsigned REQ_DATA_W = 32;
    localparam int unsigned REQ_SIZE_W = 2;

    localparam logic [REQ_SIZE_W-1:0] SIZE_B = 2'b00;
    localparam logic [REQ_SIZE_W-1:0] SIZE_H = 2'b01;
    localparam logic [REQ_SIZE_W-1:0] SIZE_W = 2'b10;
    localparam logic [REQ_SIZE_W-1:0] SIZE_X = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_SIZE_W-1:0] size;
        logic                  uns;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a right-aligned access and a 32-bit memory word:
// store strobes/replication, load extraction/extension and alignment check.
module mem_lane_align
    import mem_if_defs::*;
(
    input  logic [1:0]            addr_lo,
    input  logic [REQ_SIZE_W-1:0] size,
    input  logic                  is_unsigned,
    input  logic [REQ_DATA_W-1:0] wdata,
    input  logic [REQ_DATA_W-1:0] rdata_raw,
    output logic [3:0]            strb_c,
    output logic [REQ_DATA_W-1:0] wdata_rep_c,
    output logic [REQ_DATA_W-1:0] rdata_ext_c,
    output logic                  misalign_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        strb_c      = 4'b0000;
        wdata_rep_c = '0;
        rdata_ext_c = '0;
        misalign_c  = 1'b0;
        byte_c      = rdata_raw[{addr_lo, 3'b000} +: 8];
        half_c      = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        case (size)
            SIZE_B: begin
                strb_c      = 4'b0001 << addr_lo;
                wdata_rep_c = {4{wdata[7:0]}};
                rdata_ext_c = is_unsigned ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
            end
            SIZE_H: begin
                strb_c      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep_c = {2{wdata[15:0]}};
                rdata_ext_c = is_unsigned ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
                misalign_c  = addr_lo[0];
            end
            SIZE_W: begin
                strb_c      = 4'b1111;
                wdata_rep_c = wdata;
                rdata_ext_c = rdata_raw;
                misalign_c  = (addr_lo != 2'b00);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering one load/store at a time over valid/ready
// request and response channels, with a fixed number of wait states.
module data_mem_responder
    import mem_if_defs::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [REQ_SIZE_W-1:0] req_size,
    input  logic                  req_unsigned,
    input  logic [REQ_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REQ_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = 4;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mem_req_t              req_q, req_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [REQ_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [REQ_DATA_W-1:0] mem_array [DEPTH];
    logic [IDX_W-1:0]      mem_idx_c;
    logic [REQ_DATA_W-1:0] mem_word_c;
    logic                  mem_we_c;

    logic [3:0]            strb_c;
    logic [REQ_DATA_W-1:0] wdata_rep_c;
    logic [REQ_DATA_W-1:0] rdata_ext_c;
    logic                  misalign_c;
    logic                  out_of_range_c;
    logic                  err_c;

    assign mem_idx_c      = req_q.addr[ADDR_W-1:2];
    assign mem_word_c     = mem_array[mem_idx_c];
    assign out_of_range_c = ((req_q.addr >> ADDR_W) != '0);
    assign err_c          = out_of_range_c || (req_q.size == SIZE_X) || misalign_c;

    mem_lane_align u_align (
        .addr_lo     (req_q.addr[1:0]),
        .size        (req_q.size),
        .is_unsigned (req_q.uns),
        .wdata       (req_q.wdata),
        .rdata_raw   (mem_word_c),
        .strb_c      (strb_c),
        .wdata_rep_c (wdata_rep_c),
        .rdata_ext_c (rdata_ext_c),
        .misalign_c  (misalign_c)
    );

    // Commit happens on the edge that leaves WAIT with the counter exhausted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.addr  = req_addr;
                    req_d.size  = req_size;
                    req_d.uns   = req_unsigned;
                    req_d.wdata = req_wdata;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we_c    = req_q.we && !err_c;
                    rsp_err_d   = err_c;
                    rsp_rdata_d = (err_c || req_q.we) ? '0 : rdata_ext_c;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is not reset; only strobed byte lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_c[b]) begin
                    mem_array[mem_idx_c][8*b +: 8] <= wdata_rep_c[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with none, sharing clock and reset.
module tb_data_mem_responder;

    logic        clk;
    logic        reset_n;

    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_we1, req_unsigned1;
    logic [31:0] req_addr1, req_wdata1;
    logic [1:0]  req_size1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut_zw (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_size(req_size1), .req_unsigned(req_unsigned1),
        .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request while IDLE and let the next edge accept it.
    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Edges from the accepting edge until rsp_valid is seen, bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        issue(tag, we, addr, size, uns, wdata);
        wait_rsp(lat);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        tick();
        check({tag, "_back_idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_size1 = 2'b10;
        req_unsigned1 = 1'b0; req_wdata1 = '0; rsp_ready1 = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Word round-trip
        xact("sw_0c", 1'b1, 32'h0C, 2'b10, 1'b0, 32'h0000000F, 32'h0, 1'b0);
        xact("lw_0c", 1'b0, 32'h0C, 2'b10, 1'b0, 32'h0, 32'h0000000F, 1'b0);

        // Byte/half lanes and extension
        xact("sw_10", 1'b1, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("sb_11", 1'b1, 32'h11, 2'b00, 1'b0, 32'h00000080, 32'h0, 1'b0);
        xact("lb_11", 1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        xact("lbu_11", 1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);
        xact("lw_10a", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h00008000, 1'b0);
        xact("sh_12", 1'b1, 32'h12, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 1'b0);
        xact("lw_10b", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hBEEF8000, 1'b0);
        xact("lh_12", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
        xact("lhu_12", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h0000BEEF, 1'b0);
        xact("lb_13", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0);

        // Error cases leave memory untouched
        xact("sw_00", 1'b1, 32'h00, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("err_lw_0e", 1'b0, 32'h0E, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("err_sh_0d", 1'b1, 32'h0D, 2'b01, 1'b0, 32'h0000AAAA, 32'h0, 1'b1);
        xact("err_sz11", 1'b1, 32'h0C, 2'b11, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1);
        xact("err_lsz11", 1'b0, 32'h0C, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("err_oor", 1'b1, 32'h1000, 2'b10, 1'b0, 32'h55555555, 32'h0, 1'b1);
        xact("post_err_0c", 1'b0, 32'h0C, 2'b10, 1'b0, 32'h0, 32'h0000000F, 1'b0);
        xact("post_err_00", 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

        // Backpressure with a second request pending
        rsp_ready = 1'b0;
        issue("bp_lw", 1'b0, 32'h0C, 2'b10, 1'b0, 32'h0);
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'd3);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, 32'h0000000F);
            check("bp_err", {31'b0, rsp_err}, 32'd0);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_hs_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_hs_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("bp_second_acc", {31'b0, req_ready}, 32'd0);
        wait_rsp(lat);
        check("bp_second_lat", 32'(lat), 32'd3);
        check("bp_second_rdata", rsp_rdata, 32'hBEEF8000);
        tick();

        // Reset during WAIT drops an uncommitted store
        xact("sw_20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        issue("rw_sw", 1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678);
        tick();
        reset_n = 1'b0;
        #1;
        check("rw_req_ready", {31'b0, req_ready}, 32'd1);
        check("rw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        xact("rw_lw_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("rw_lw_0c", 1'b0, 32'h0C, 2'b10, 1'b0, 32'h0, 32'h0000000F, 1'b0);

        // Zero wait states, request held valid throughout
        req_we1 = 1'b1; req_addr1 = 32'h04; req_size1 = 2'b10; req_wdata1 = 32'h11223344;
        req_valid1 = 1'b1;
        check("zw_rdy0", {31'b0, req_ready1}, 32'd1);
        tick();
        req_we1 = 1'b0;
        check("zw_acc0_ready", {31'b0, req_ready1}, 32'd0);
        check("zw_acc0_valid", {31'b0, rsp_valid1}, 32'd0);
        tick();
        check("zw_rsp0_valid", {31'b0, rsp_valid1}, 32'd1);
        check("zw_rsp0_rdata", rsp_rdata1, 32'h0);
        check("zw_rsp0_ready", {31'b0, req_ready1}, 32'd0);
        tick();
        check("zw_idle_ready", {31'b0, req_ready1}, 32'd1);
        check("zw_idle_valid", {31'b0, rsp_valid1}, 32'd0);
        tick();
        check("zw_acc1_ready", {31'b0, req_ready1}, 32'd0);
        req_valid1 = 1'b0;
        tick();
        check("zw_rsp1_valid", {31'b0, rsp_valid1}, 32'd1);
        check("zw_rsp1_rdata", rsp_rdata1, 32'h11223344);
        check("zw_rsp1_err", {31'b0, rsp_err1}, 32'd0);
        tick();
        check("zw_end_ready", {31'b0, req_ready1}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
